// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHT branch predictor with combinational IF-stage lookup,
// ID-stage resolution/update, and saturating lookup/mispredict counters.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_W    = 8,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              if_valid,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic [1:0]        upd_kind,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  perf_lookups,
  output logic [CNT_W-1:0]  perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;
  localparam logic [1:0]          KIND_BRANCH = 2'b00;
  localparam logic [1:0]          KIND_NONE   = 2'b11;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [CNT_W-1:0] lookups_q, lookups_d;
  logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

  logic [IDX_W-1:0]    ifIdx, updIdx;
  logic [TAG_W-1:0]    ifTag, updTag;
  logic                ifHit, updHit, updActive, isBranch;
  logic                entWe;
  logic [XLEN-1:0]     entTarget_d;
  logic [CTR_BITS-1:0] entCtr_d;
  logic                unusedPcBits;

  assign ifIdx  = if_pc[IDX_W+1:2];
  assign ifTag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Only the index and tag fields of each PC participate in lookup.
  assign unusedPcBits = ^{if_pc, upd_pc};

  assign ifHit       = valid_q[ifIdx] && (tag_q[ifIdx] == ifTag);
  assign pred_taken  = ifHit && ctr_q[ifIdx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[ifIdx] : (if_pc + XLEN'(4));

  assign updActive = upd_valid && (upd_kind != KIND_NONE);
  assign isBranch  = (upd_kind == KIND_BRANCH);
  assign updHit    = valid_q[updIdx] && (tag_q[updIdx] == updTag);

  assign mispredict  = updActive &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = !mispredict ? '0 :
                       (upd_taken ? upd_target : (upd_pc + XLEN'(4)));

  // Next contents of the single entry touched by a resolving instruction.
  always_comb begin
    entWe       = 1'b0;
    entTarget_d = target_q[updIdx];
    entCtr_d    = ctr_q[updIdx];
    if (updActive) begin
      if (updHit) begin
        entWe = 1'b1;
        if (isBranch) begin
          if (upd_taken) begin
            entTarget_d = upd_target;
            if (ctr_q[updIdx] != CTR_MAX) entCtr_d = ctr_q[updIdx] + CTR_BITS'(1);
          end else if (ctr_q[updIdx] != '0) begin
            entCtr_d = ctr_q[updIdx] - CTR_BITS'(1);
          end
        end else begin
          entTarget_d = upd_target;
          entCtr_d    = CTR_MAX;
        end
      end else if (upd_taken) begin
        entWe       = 1'b1;
        entTarget_d = upd_target;
        entCtr_d    = isBranch ? CTR_WT : CTR_MAX;
      end
    end
  end

  always_comb begin
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (if_valid && (lookups_q != CNT_MAX))
      lookups_d = lookups_q + CNT_W'(1);
    if (mispredict && (mispredicts_q != CNT_MAX))
      mispredicts_d = mispredicts_q + CNT_W'(1);
  end

  // Reset wins over a same-cycle update so no history survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (entWe) begin
        valid_q[updIdx]  <= 1'b1;
        tag_q[updIdx]    <= updTag;
        target_q[updIdx] <= entTarget_d;
        ctr_q[updIdx]    <= entCtr_d;
      end
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign perf_lookups     = lookups_q;
  assign perf_mispredicts = mispredicts_q;

endmodule
